// File: rtl/shunt_frame_pkg.sv
// Shared constants and state encoding for the shunt frame transmitter.
package shunt_frame_pkg;

  localparam logic [7:0] SOF_BYTE  = 8'hA5;
  localparam int         HDR_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    ID,
    LEN,
    WAIT_WORD,
    PAY,
    CSUM
  } state_e;

  // Total bytes on the wire for a frame of len payload words: header, payload, checksum.
  function automatic int frame_bytes(input logic [7:0] len);
    return 4 * int'(len) + HDR_BYTES + 1;
  endfunction

endpackage

// File: rtl/shunt_frame_csum.sv
// Running 8-bit modular checksum: cleared at frame start, adds one byte per accepted byte.
module shunt_frame_csum (
  input  logic       clk_i,
  input  logic       reset_n,
  input  logic       clear_i,
  input  logic       add_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = 8'h00;
    end else if (add_i) begin
      sum_d = sum_q + byte_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/shunt_frame_tx.sv
// Serializes a header, a word-fed payload (MSB first) and a checksum into a byte stream
// with valid/ready handshakes on both the word input and the byte output.
module shunt_frame_tx
  import shunt_frame_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [7:0]  id_i,
  input  logic [7:0]  len_i,
  input  logic        word_valid_i,
  input  logic [31:0] word_i,
  output logic        word_ready_o,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e      state_q, state_d;
  logic [7:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        len_ok;
  logic        start_ok;
  logic        byte_hs;
  logic        word_hs;
  logic        csum_add;
  logic [7:0]  csum_sum;

  assign len_ok   = (len_i != 8'd0) && (len_i <= MAX_LEN_B);
  assign start_ok = (state_q == IDLE) && start_i && len_ok;
  assign byte_hs  = byte_valid_o && byte_ready_i;
  assign word_hs  = word_valid_i && word_ready_o;
  // The SOF byte is excluded from the sum; everything after it is included.
  assign csum_add = byte_hs && ((state_q == ID) || (state_q == LEN) || (state_q == PAY));

  shunt_frame_csum u_csum (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .clear_i (start_ok),
    .add_i   (csum_add),
    .byte_i  (byte_o),
    .sum_o   (csum_sum)
  );

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      id_q       <= 8'h00;
      len_q      <= 8'h00;
      word_q     <= 32'h0;
      word_cnt_q <= 8'h00;
      byte_idx_q <= 2'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      len_q      <= len_d;
      word_q     <= word_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    len_d      = len_q;
    word_d     = word_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d    = SOF;
          id_d       = id_i;
          len_d      = len_i;
          word_cnt_d = 8'h00;
          byte_idx_d = 2'd0;
        end else if (start_i) begin
          err_d = 1'b1;
        end
      end
      SOF:  if (byte_hs) state_d = ID;
      ID:   if (byte_hs) state_d = LEN;
      LEN:  if (byte_hs) state_d = WAIT_WORD;
      WAIT_WORD: begin
        if (word_hs) begin
          state_d    = PAY;
          word_d     = word_i;
          word_cnt_d = word_cnt_q + 8'd1;
        end
      end
      PAY: begin
        if (byte_hs) begin
          byte_idx_d = byte_idx_q + 2'd1;
          // word_cnt_q already includes the word being sent.
          if (byte_idx_q == 2'd3) begin
            state_d = (word_cnt_q == len_q) ? CSUM : WAIT_WORD;
          end
        end
      end
      CSUM: begin
        if (byte_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_o       = 8'h00;
    byte_valid_o = 1'b0;
    word_ready_o = 1'b0;
    busy_o       = (state_q != IDLE);
    unique case (state_q)
      SOF: begin
        byte_o       = SOF_BYTE;
        byte_valid_o = 1'b1;
      end
      ID: begin
        byte_o       = id_q;
        byte_valid_o = 1'b1;
      end
      LEN: begin
        byte_o       = len_q;
        byte_valid_o = 1'b1;
      end
      WAIT_WORD: word_ready_o = 1'b1;
      PAY: begin
        byte_valid_o = 1'b1;
        unique case (byte_idx_q)
          2'd0:    byte_o = word_q[31:24];
          2'd1:    byte_o = word_q[23:16];
          2'd2:    byte_o = word_q[15:8];
          default: byte_o = word_q[7:0];
        endcase
      end
      CSUM: begin
        byte_o       = csum_sum;
        byte_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_shunt_frame_tx.sv
// Self-checking bench: a queue-based frame model predicts every output each cycle,
// with directed scenarios pinned by hand-computed byte streams plus randomized frames.
module tb_shunt_frame_tx;

  localparam int MAX_LEN = 16;

  logic        clk_i        = 1'b0;
  logic        reset_n      = 1'b0;
  logic        start_i      = 1'b0;
  logic [7:0]  id_i         = 8'h00;
  logic [7:0]  len_i        = 8'h00;
  logic        word_valid_i = 1'b0;
  logic [31:0] word_i       = 32'h0;
  logic        byte_ready_i = 1'b1;
  logic        word_ready_o;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  shunt_frame_tx #(.MAX_LEN(MAX_LEN)) dut (
    .clk_i        (clk_i),
    .reset_n      (reset_n),
    .start_i      (start_i),
    .id_i         (id_i),
    .len_i        (len_i),
    .word_valid_i (word_valid_i),
    .word_i       (word_i),
    .word_ready_o (word_ready_o),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  expQ[$];
  logic [7:0]  txLog[$];
  logic [31:0] srcWords[$];
  int          srcGaps[$];
  bit          modelBusy  = 1'b0;
  bit          expectDone = 1'b0;
  bit          expectErr  = 1'b0;
  int          wordsLeft  = 0;
  logic [7:0]  modelSum   = 8'h00;
  int          doneCount  = 0;
  int          errCount   = 0;
  int          validSeen  = 0;
  int          adCycles   = 0;
  int          readyMode  = 0;
  int          stallCnt   = 0;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expQ holds bytes owed downstream; words join it only when the DUT takes them.
  task automatic checkOutput();
    bit         busyNow;
    bit         expValid;
    bit         expWordReady;
    logic [7:0] b;
    if (!reset_n) begin
      checkEq("reset_outputs",
              32'({byte_o, byte_valid_o, word_ready_o, busy_o, done_o, err_o}), 32'h0);
      expQ.delete();
      modelBusy  = 1'b0;
      wordsLeft  = 0;
      expectDone = 1'b0;
      expectErr  = 1'b0;
      return;
    end
    busyNow      = modelBusy;
    expValid     = modelBusy && (expQ.size() > 0);
    expWordReady = modelBusy && (expQ.size() == 0) && (wordsLeft > 0);
    checkEq("busy_o", 32'(busy_o), 32'(busyNow));
    checkEq("byte_valid_o", 32'(byte_valid_o), 32'(expValid));
    checkEq("word_ready_o", 32'(word_ready_o), 32'(expWordReady));
    checkEq("done_o", 32'(done_o), 32'(expectDone));
    checkEq("err_o", 32'(err_o), 32'(expectErr));
    if (expValid) checkEq("byte_o", 32'(byte_o), 32'(expQ[0]));
    if (done_o === 1'b1) doneCount++;
    if (err_o === 1'b1) errCount++;
    if (byte_valid_o === 1'b1) validSeen++;
    if (byte_valid_o === 1'b1 && byte_o == 8'hAD) adCycles++;
    expectDone = 1'b0;
    expectErr  = 1'b0;
    if (expValid && byte_ready_i) begin
      b = expQ.pop_front();
      txLog.push_back(b);
      if (expQ.size() == 0 && wordsLeft == 0) begin
        modelBusy  = 1'b0;
        expectDone = 1'b1;
      end
    end
    if (expWordReady && word_valid_i) begin
      for (int k = 3; k >= 0; k--) begin
        b = word_i[8*k +: 8];
        expQ.push_back(b);
        modelSum = modelSum + b;
      end
      wordsLeft--;
      if (wordsLeft == 0) expQ.push_back(modelSum);
    end
    if (start_i && !busyNow) begin
      if (len_i >= 8'd1 && int'(len_i) <= MAX_LEN) begin
        modelBusy = 1'b1;
        wordsLeft = int'(len_i);
        modelSum  = id_i + len_i;
        expQ.push_back(8'hA5);
        expQ.push_back(id_i);
        expQ.push_back(len_i);
      end else begin
        expectErr = 1'b1;
      end
    end
  endtask

  always @(negedge clk_i) checkOutput();

  // Downstream ready: always, random, or a 3-cycle stall on the 0xAD byte.
  always begin
    @(posedge clk_i);
    #1;
    case (readyMode)
      0: byte_ready_i = 1'b1;
      1: byte_ready_i = ($urandom_range(3) != 0);
      default: begin
        if (byte_valid_o && byte_o == 8'hAD && stallCnt < 3) begin
          byte_ready_i = 1'b0;
          stallCnt++;
        end else begin
          byte_ready_i = 1'b1;
        end
      end
    endcase
  end

  // Word source: each word waits its gap (counted in word_ready_o cycles) before being offered.
  always begin
    bit taken;
    @(negedge clk_i);
    taken = word_valid_i && word_ready_o;
    @(posedge clk_i);
    #1;
    if (taken && srcWords.size() > 0) begin
      void'(srcWords.pop_front());
      void'(srcGaps.pop_front());
    end
    if (srcGaps.size() > 0 && srcGaps[0] > 0) begin
      if (word_ready_o) srcGaps[0] = srcGaps[0] - 1;
      word_valid_i = 1'b0;
      word_i       = $urandom;
    end else if (srcWords.size() > 0) begin
      word_valid_i = 1'b1;
      word_i       = srcWords[0];
    end else begin
      word_valid_i = 1'b0;
      word_i       = $urandom;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic pushWord(input logic [31:0] w, input int gap);
    srcWords.push_back(w);
    srcGaps.push_back(gap);
  endtask

  task automatic applyStimulus(input logic [7:0] id, input logic [7:0] len);
    start_i = 1'b1;
    id_i    = id;
    len_i   = len;
    tick();
    start_i = 1'b0;
    id_i    = 8'($urandom);
    len_i   = 8'($urandom);
  endtask

  task automatic waitDone(input int target);
    int n = 0;
    while (doneCount < target && n < 600) begin
      tick();
      n++;
    end
    checkEq("done_count", 32'(doneCount), 32'(target));
    tick();
  endtask

  task automatic checkLog(input string name, input logic [7:0] want[$]);
    checkEq({name, "_len"}, 32'(txLog.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < txLog.size(); i++) begin
      checkEq(name, 32'(txLog[i]), 32'(want[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] want[$];
    int d0;
    int e0;
    int v0;
    int n;

    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Single-word frame with free-flowing downstream.
    txLog.delete();
    d0 = doneCount;
    pushWord(32'hDEADBEEF, 0);
    applyStimulus(8'h12, 8'd1);
    waitDone(d0 + 1);
    want = '{8'hA5, 8'h12, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h4B};
    checkLog("frame_basic", want);

    // Same frame with a 3-cycle downstream stall on 0xAD.
    txLog.delete();
    readyMode = 2;
    stallCnt  = 0;
    adCycles  = 0;
    d0 = doneCount;
    pushWord(32'hDEADBEEF, 0);
    applyStimulus(8'h12, 8'd1);
    waitDone(d0 + 1);
    checkLog("frame_stall", want);
    checkEq("ad_hold_cycles", 32'(adCycles), 32'd4);
    readyMode = 0;

    // Rejected lengths.
    e0 = errCount;
    v0 = validSeen;
    applyStimulus(8'h01, 8'd0);
    repeat (3) tick();
    applyStimulus(8'h02, 8'(MAX_LEN + 1));
    repeat (3) tick();
    checkEq("err_pulses", 32'(errCount - e0), 32'd2);
    checkEq("no_valid_on_reject", 32'(validSeen - v0), 32'd0);

    // Two words with a 5-cycle word gap before the second.
    txLog.delete();
    d0 = doneCount;
    pushWord(32'h01020304, 0);
    pushWord(32'h05060708, 5);
    applyStimulus(8'h20, 8'd2);
    waitDone(d0 + 1);
    checkEq("gap_frame_bytes", 32'(txLog.size()), 32'd12);
    if (txLog.size() == 12) checkEq("gap_frame_csum", 32'(txLog[11]), 32'h46);

    // Reset after the id byte aborts the frame.
    txLog.delete();
    d0 = doneCount;
    pushWord(32'h11111111, 0);
    pushWord(32'h22222222, 0);
    pushWord(32'h33333333, 0);
    applyStimulus(8'h33, 8'd3);
    n = 0;
    while (txLog.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    reset_n = 1'b0;
    #1;
    checkEq("async_reset_now",
            32'({byte_o, byte_valid_o, word_ready_o, busy_o, done_o, err_o}), 32'h0);
    srcWords.delete();
    srcGaps.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checkEq("no_done_after_abort", 32'(doneCount), 32'(d0));
    txLog.delete();
    pushWord(32'hCAFEF00D, 0);
    applyStimulus(8'h44, 8'd1);
    waitDone(d0 + 1);
    want = '{8'hA5, 8'h44, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0A};
    checkLog("frame_after_reset", want);

    // Start pulses while busy are ignored.
    txLog.delete();
    d0 = doneCount;
    pushWord(32'hA0A1A2A3, 0);
    pushWord(32'hB0B1B2B3, 0);
    applyStimulus(8'h55, 8'd2);
    tick();
    applyStimulus(8'h66, 8'd1);
    repeat (3) tick();
    applyStimulus(8'h77, 8'd1);
    waitDone(d0 + 1);
    repeat (20) tick();
    checkEq("single_frame_done", 32'(doneCount - d0), 32'd1);
    checkEq("single_frame_bytes", 32'(txLog.size()), 32'd12);
    if (txLog.size() > 1) checkEq("single_frame_id", 32'(txLog[1]), 32'h55);

    // Randomized frames with random backpressure and word gaps.
    readyMode = 1;
    for (int f = 0; f < 30; f++) begin
      int r;
      int len;
      r = $urandom_range(9);
      if (r == 0) len = 0;
      else if (r == 1) len = $urandom_range(255, MAX_LEN + 1);
      else if (r == 2) len = MAX_LEN;
      else len = $urandom_range(MAX_LEN, 1);
      if (len == 0 || len > MAX_LEN) begin
        e0 = errCount;
        applyStimulus(8'($urandom), 8'(len));
        repeat (2) tick();
        checkEq("rand_err", 32'(errCount - e0), 32'd1);
      end else begin
        d0 = doneCount;
        for (int w = 0; w < len; w++) pushWord($urandom, $urandom_range(3));
        applyStimulus(8'($urandom), 8'(len));
        waitDone(d0 + 1);
      end
    end
    readyMode = 0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shunt_frame_tx.md
SHUNT_FRAME_TX -- requirements
Module: shunt_frame_tx

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload words per frame (1..255).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  frame request, sampled in IDLE only.
REQ-005 SHALL have port id_i  input  8  frame id, captured on accepted start.
REQ-006 SHALL have port len_i  input  8  payload length in 32-bit words, captured on accepted start.
REQ-007 SHALL have port word_valid_i  input  1  payload word valid.
REQ-008 SHALL have port word_i  input  32  payload word.
REQ-009 SHALL have port word_ready_o  output  1  payload word accept.
REQ-010 SHALL have port byte_o  output  8  serialized frame byte.
REQ-011 SHALL have port byte_valid_o  output  1  byte_o valid.
REQ-012 SHALL have port byte_ready_i  input  1  downstream accept.
REQ-013 SHALL have port busy_o  output  1  high from accepted start until the checksum byte is accepted.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse after the checksum byte is accepted.
REQ-015 SHALL have port err_o  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 Frame format SHALL be: SOF byte 0xA5, id, len, 4*len payload bytes (each word MSB first), checksum; total 4*len+4 bytes.
REQ-017 Checksum SHALL be the 8-bit sum, mod 256, of id, len and all payload bytes; SOF excluded.
REQ-018 FSM states SHALL be IDLE, SOF, ID, LEN, WAIT_WORD, PAY, CSUM.
REQ-019 Transitions: IDLE->SOF on start_i with 1<=len_i<=MAX_LEN; SOF->ID->LEN on each byte handshake; LEN->WAIT_WORD on handshake.
REQ-020 Transitions: WAIT_WORD->PAY on word handshake; PAY->WAIT_WORD after the 4th byte if words remain, else PAY->CSUM; CSUM->IDLE on handshake.
REQ-021 In IDLE, start_i with len_i==0 or len_i>MAX_LEN SHALL pulse err_o the next cycle; FSM SHALL stay in IDLE.
REQ-022 start_i SHALL be ignored outside IDLE; id/len captured at start SHALL NOT change mid-frame.
REQ-023 Byte handshake = byte_valid_o && byte_ready_i in the same cycle; only then SHALL state/byte index advance.
REQ-024 While byte_valid_o=1 and byte_ready_i=0, byte_o SHALL hold stable.
REQ-025 byte_valid_o SHALL be 1 in SOF, ID, LEN, PAY, CSUM; 0 in IDLE and WAIT_WORD.
REQ-026 word_ready_o SHALL be 1 only in WAIT_WORD; word handshake = word_valid_i && word_ready_o.
REQ-027 Latency: start accepted at edge N SHALL give byte_valid_o=1 with byte_o=0xA5 after edge N; first payload byte valid the cycle after the word handshake.
REQ-028 With continuous ready/valid, throughput SHALL be one byte per cycle except one WAIT_WORD bubble per word.
REQ-029 Word counter SHALL be 8 bits and byte-in-word index 2 bits; the final-word check SHALL compare against the captured len.
REQ-030 done_o SHALL pulse exactly one cycle after the CSUM handshake; busy_o SHALL drop in the same cycle.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, byte_o=0, byte_valid_o=0, word_ready_o=0, busy_o=0, done_o=0, err_o=0, and clear the checksum and counters.
REQ-032 reset_n asserted mid-frame SHALL abort the frame with no done_o; first start after release SHALL send a complete new frame.

Structure
REQ-033 SOF constant, state enum and header byte count SHALL live in shared package shunt_frame_pkg.
REQ-034 The checksum accumulator (clear, add byte on handshake, value) SHALL be sub-module shunt_frame_csum.

Verification
REQ-035 id=0x12, len=1, word 0xDEADBEEF, ready held 1 -> bytes A5 12 01 DE AD BE EF 4B, then one done_o pulse.
REQ-036 Same frame, byte_ready_i low 3 cycles while 0xAD is presented -> 0xAD held 3 cycles, output stream identical.
REQ-037 len=0, then len=MAX_LEN+1 -> one err_o pulse each, byte_valid_o never 1, busy_o stays 0.
REQ-038 len=2, word_valid_i delayed 5 cycles before the second word -> byte_valid_o=0 for those cycles, 12 bytes total.
REQ-039 reset_n low after the ID byte -> all outputs 0 immediately; next start sends a full frame starting 0xA5.
REQ-040 start_i pulsed while busy -> ignored, exactly one frame is sent.
